// File: rtl/pkg_dtypes.sv
// Shared data types for the execution-unit interconnect channel and the
// channel arbiter FSM state.
package pkg_dtypes;

  localparam int EXEC_UNIT_ADDR_W = 16;
  localparam int EXEC_UNIT_DATA_W = 32;

  typedef logic [EXEC_UNIT_ADDR_W-1:0] type_exec_unit_addr;
  typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

  // Channel broadcast, as seen from the channel side.
  typedef struct packed {
    type_exec_unit_addr src_addr;
    type_exec_unit_data data_tx;
    logic               req_valid;
  } type_icon_tx_channel_chside;

  // Channel return, as seen from the channel side.
  typedef struct packed {
    type_exec_unit_data data_rx;
    logic               data_valid_rx;
    logic               success;
  } type_icon_rx_channel_chside;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } type_iconch_arb_state;

endpackage

// File: rtl/back_iconch_arbiter_if.sv
// Bundle of the requester-side handshake and channel signals of the
// interconnect-channel arbiter. "master" is the requester/channel environment,
// "slave" is the arbiter itself.
//
// Handshake: a requester raises req_valid[i] with stable src_addr/data and holds
// it until req_ready[i] pulses for one cycle (acceptance). Completion is a
// one-cycle resp_valid[i] pulse carrying resp_data/resp_err; there is no
// backpressure on the response.
interface back_iconch_arbiter_if
  import pkg_dtypes::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic               [NUM_REQ-1:0] req_valid;
  type_exec_unit_addr [NUM_REQ-1:0] req_src_addr;
  type_exec_unit_data [NUM_REQ-1:0] req_data;
  logic               [NUM_REQ-1:0] req_ready;
  logic               [NUM_REQ-1:0] resp_valid;
  type_exec_unit_data               resp_data;
  logic                             resp_err;
  type_icon_tx_channel_chside       icon_tx;
  type_icon_rx_channel_chside       icon_rx;
  logic                             busy;

  modport master (
    output req_valid, req_src_addr, req_data, icon_rx,
    input  req_ready, resp_valid, resp_data, resp_err, icon_tx, busy
  );

  modport slave (
    input  req_valid, req_src_addr, req_data, icon_rx,
    output req_ready, resp_valid, resp_data, resp_err, icon_tx, busy
  );

endinterface

// File: rtl/back_rr_arbiter.sv
// Round-robin priority selector: picks the first requesting index at or after
// ptr_i, wrapping from NUM_REQ-1 back to 0. Purely combinational.
module back_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan from ptr_i upward (mod NUM_REQ); first hit wins.
  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (!valid_o && req_i[IDX_W'(j)]) begin
        valid_o             = 1'b1;
        grant_o[IDX_W'(j)]  = 1'b1;
        idx_o               = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/back_iconch_arbiter.sv
// Interconnect-channel arbiter: grants one execution unit at a time onto the
// shared channel, holds the broadcast until the channel reports success or a
// timeout expires, then returns a one-cycle response to the granted unit.
module back_iconch_arbiter
  import pkg_dtypes::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic               [NUM_REQ-1:0] req_valid_i,
  input  type_exec_unit_addr [NUM_REQ-1:0] req_src_addr_i,
  input  type_exec_unit_data [NUM_REQ-1:0] req_data_i,
  output logic               [NUM_REQ-1:0] req_ready_o,
  output logic               [NUM_REQ-1:0] resp_valid_o,
  output type_exec_unit_data               resp_data_o,
  output logic                             resp_err_o,
  output type_icon_tx_channel_chside       icon_tx_o,
  input  type_icon_rx_channel_chside       icon_rx_i,
  output logic                             busy_o,
  output type_iconch_arb_state             dbg_state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value in the last XFER cycle before the timeout fires.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

  type_iconch_arb_state state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  type_exec_unit_addr   addr_q, addr_d;
  type_exec_unit_data   tx_data_q, tx_data_d;
  type_exec_unit_data   rsp_data_q, rsp_data_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 rx_ok;

  back_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign rx_ok = icon_rx_i.data_valid_rx && icon_rx_i.success;

  // Next-state logic: grant in IDLE, wait for success/timeout in XFER,
  // advance the round-robin pointer in DONE.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          idx_d     = arb_idx;
          addr_d    = req_src_addr_i[arb_idx];
          tx_data_d = req_data_i[arb_idx];
          cnt_d     = '0;
          state_d   = XFER;
        end
      end
      XFER: begin
        // Success is tested first so it wins over a coincident timeout.
        if (rx_ok) begin
          rsp_data_d = icon_rx_i.data_rx;
          err_d      = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TO_LAST) begin
            rsp_data_d = '0;
            err_d      = 1'b1;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        rr_ptr_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-value registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  // Outputs decoded from the state; everything is zero unless its state owns it.
  // req_ready is gated by reset_n because it is combinational from req_valid_i.
  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    resp_data_o  = '0;
    resp_err_o   = 1'b0;
    icon_tx_o    = '0;
    case (state_q)
      IDLE: begin
        if (reset_n) req_ready_o = arb_grant;
      end
      XFER: begin
        icon_tx_o.req_valid = 1'b1;
        icon_tx_o.src_addr  = addr_q;
        icon_tx_o.data_tx   = tx_data_q;
      end
      DONE: begin
        resp_valid_o[idx_q] = 1'b1;
        resp_data_o         = rsp_data_q;
        resp_err_o          = err_q;
      end
      default: ;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_back_iconch_arbiter.sv
// Directed self-checking bench for back_iconch_arbiter (NUM_REQ=4,
// TIMEOUT_CYCLES=15). Inputs change 1 time unit after a rising edge and
// outputs are sampled 1 time unit later, both well away from the edge.
module tb_back_iconch_arbiter;
  import pkg_dtypes::*;

  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  back_iconch_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  type_iconch_arb_state dbg_state;

  back_iconch_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid_i    (bus.req_valid),
    .req_src_addr_i (bus.req_src_addr),
    .req_data_i     (bus.req_data),
    .req_ready_o    (bus.req_ready),
    .resp_valid_o   (bus.resp_valid),
    .resp_data_o    (bus.resp_data),
    .resp_err_o     (bus.resp_err),
    .icon_tx_o      (bus.icon_tx),
    .icon_rx_i      (bus.icon_rx),
    .busy_o         (bus.busy),
    .dbg_state_o    (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic type_icon_rx_channel_chside mk_rx(input type_exec_unit_data d,
                                                       input logic v, input logic s);
    type_icon_rx_channel_chside r;
    r.data_rx       = d;
    r.data_valid_rx = v;
    r.success       = s;
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req_valid = 4'b1111;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b exp 0000", bus.req_ready);
    end
    n_tests++;
    if (bus.resp_valid !== 4'b0000 || bus.resp_err !== 1'b0 || bus.resp_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_resp: got v=%b e=%b d=%h exp 0", bus.resp_valid, bus.resp_err, bus.resp_data);
    end
    n_tests++;
    if (bus.icon_tx !== '0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_tx_busy: got tx=%h busy=%b exp 0", bus.icon_tx, bus.busy);
    end
    tick();
    tick();
    bus.req_valid = 4'b0000;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) begin
      int e;
      logic [3:0] g;
      e = k % 4;
      g = 4'b0001 << e;
      bus.req_valid = 4'b1111;
      #1;
      n_tests++;
      if (bus.req_ready !== g) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %b exp %b", k, bus.req_ready, g);
      end
      tick();
      bus.icon_rx = mk_rx(32'hC000_0000 + 32'(k), 1'b1, 1'b1);
      #1;
      n_tests++;
      if (bus.icon_tx.req_valid !== 1'b1 || bus.icon_tx.src_addr !== 16'hA000 + 16'(e) ||
          bus.req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL rr_xfer_%0d: got v=%b a=%h rdy=%b exp v=1 a=%h rdy=0000",
                           k, bus.icon_tx.req_valid, bus.icon_tx.src_addr, bus.req_ready, 16'hA000 + 16'(e));
      end
      tick();
      bus.icon_rx = '0;
      #1;
      n_tests++;
      if (bus.resp_valid !== g || bus.resp_data !== 32'hC000_0000 + 32'(k) ||
          bus.resp_err !== 1'b0 || bus.req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL rr_resp_%0d: got v=%b d=%h e=%b rdy=%b exp v=%b d=%h e=0 rdy=0000",
                           k, bus.resp_valid, bus.resp_data, bus.resp_err, bus.req_ready, g, 32'hC000_0000 + 32'(k));
      end
      tick();
    end
    bus.req_valid = 4'b0000;
  endtask

  // rr_ptr is 1 here, so 4'b0100 resolves to index 2.
  task automatic test_single();
    bus.req_valid = 4'b0100;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0100 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_grant: got rdy=%b busy=%b exp 0100/0", bus.req_ready, bus.busy);
    end
    tick();
    bus.req_valid = 4'b0000;
    bus.icon_rx   = mk_rx(32'h1234_5678, 1'b1, 1'b1);
    #1;
    n_tests++;
    if (bus.icon_tx.req_valid !== 1'b1 || bus.icon_tx.src_addr !== 16'hA002 ||
        bus.icon_tx.data_tx !== 32'hD000_0002 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL single_tx: got v=%b a=%h d=%h busy=%b exp 1/A002/D0000002/1",
                         bus.icon_tx.req_valid, bus.icon_tx.src_addr, bus.icon_tx.data_tx, bus.busy);
    end
    tick();
    bus.icon_rx = '0;
    #1;
    n_tests++;
    if (bus.resp_valid !== 4'b0100 || bus.resp_err !== 1'b0 || bus.resp_data !== 32'h1234_5678 ||
        bus.icon_tx !== '0) begin
      n_fail++; $display("FAIL single_resp: got v=%b e=%b d=%h tx=%h exp 0100/0/12345678/0",
                         bus.resp_valid, bus.resp_err, bus.resp_data, bus.icon_tx);
    end
    tick();
    n_tests++;
    if (bus.resp_valid !== 4'b0000 || bus.resp_data !== 32'h0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_after: got v=%b d=%h busy=%b exp 0/0/0", bus.resp_valid, bus.resp_data, bus.busy);
    end
  endtask

  // rr_ptr is 3; 4'b0010 resolves to index 1 after wrapping.
  task automatic test_retry();
    bus.req_valid = 4'b0010;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL retry_grant: got %b exp 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    for (int r = 0; r < 3; r++) begin
      bus.icon_rx = mk_rx(32'hBAD0_0000 + 32'(r), 1'b1, 1'b0);
      #1;
      n_tests++;
      if (bus.icon_tx.req_valid !== 1'b1 || bus.icon_tx.src_addr !== 16'hA001 ||
          bus.resp_valid !== 4'b0000) begin
        n_fail++; $display("FAIL retry_hold_%0d: got v=%b a=%h rv=%b exp 1/A001/0000",
                           r, bus.icon_tx.req_valid, bus.icon_tx.src_addr, bus.resp_valid);
      end
      tick();
    end
    bus.icon_rx = mk_rx(32'h5555_AAAA, 1'b1, 1'b1);
    #1;
    n_tests++;
    if (bus.icon_tx.req_valid !== 1'b1 || bus.icon_tx.data_tx !== 32'hD000_0001) begin
      n_fail++; $display("FAIL retry_last_tx: got v=%b d=%h exp 1/D0000001", bus.icon_tx.req_valid, bus.icon_tx.data_tx);
    end
    tick();
    bus.icon_rx = '0;
    #1;
    n_tests++;
    if (bus.resp_valid !== 4'b0010 || bus.resp_err !== 1'b0 || bus.resp_data !== 32'h5555_AAAA) begin
      n_fail++; $display("FAIL retry_resp: got v=%b e=%b d=%h exp 0010/0/5555aaaa", bus.resp_valid, bus.resp_err, bus.resp_data);
    end
    tick();
    n_tests++;
    if (bus.resp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL retry_single_pulse: got %b exp 0000", bus.resp_valid);
    end
  endtask

  // rr_ptr is 2; 4'b1000 resolves to index 3. No channel data at all.
  task automatic test_timeout();
    bus.req_valid = 4'b1000;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL to_grant: got %b exp 1000", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    for (int c = 1; c <= TIMEOUT_CYCLES; c++) begin
      n_tests++;
      if (bus.icon_tx.req_valid !== 1'b1 || bus.resp_valid !== 4'b0000) begin
        n_fail++; $display("FAIL to_xfer_cycle_%0d: got v=%b rv=%b exp 1/0000", c, bus.icon_tx.req_valid, bus.resp_valid);
      end
      tick();
    end
    n_tests++;
    if (bus.resp_valid !== 4'b1000 || bus.resp_err !== 1'b1 || bus.resp_data !== 32'h0 ||
        bus.icon_tx !== '0) begin
      n_fail++; $display("FAIL to_resp: got v=%b e=%b d=%h tx=%h exp 1000/1/0/0",
                         bus.resp_valid, bus.resp_err, bus.resp_data, bus.icon_tx);
    end
    tick();
    // Pointer now 0: requester 0 beats requester 3.
    bus.req_valid = 4'b1001;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL to_ptr_advance: got %b exp 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    bus.icon_rx   = mk_rx(32'h0000_0A0A, 1'b1, 1'b1);
    tick();
    bus.icon_rx = '0;
    #1;
    n_tests++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_err !== 1'b0 || bus.resp_data !== 32'h0000_0A0A) begin
      n_fail++; $display("FAIL to_followup_resp: got v=%b e=%b d=%h exp 0001/0/00000a0a",
                         bus.resp_valid, bus.resp_err, bus.resp_data);
    end
    tick();
  endtask

  // rr_ptr is 1; 4'b0100 resolves to index 2. Success lands in the 15th XFER cycle.
  task automatic test_success_at_timeout();
    bus.req_valid = 4'b0100;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL sat_grant: got %b exp 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    for (int c = 1; c < TIMEOUT_CYCLES; c++) begin
      tick();
    end
    bus.icon_rx = mk_rx(32'hFEED_BEEF, 1'b1, 1'b1);
    #1;
    n_tests++;
    if (bus.icon_tx.req_valid !== 1'b1 || bus.resp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL sat_last_xfer: got v=%b rv=%b exp 1/0000", bus.icon_tx.req_valid, bus.resp_valid);
    end
    tick();
    bus.icon_rx = '0;
    #1;
    n_tests++;
    if (bus.resp_valid !== 4'b0100 || bus.resp_err !== 1'b0 || bus.resp_data !== 32'hFEED_BEEF) begin
      n_fail++; $display("FAIL sat_resp: got v=%b e=%b d=%h exp 0100/0/feedbeef", bus.resp_valid, bus.resp_err, bus.resp_data);
    end
    tick();
  endtask

  // rr_ptr is 3; 4'b0100 resolves to index 2. Reset lands mid-XFER.
  task automatic test_reset_mid_xfer();
    bus.req_valid = 4'b0100;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL rst_grant: got %b exp 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    #1;
    n_tests++;
    if (bus.icon_tx.req_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_xfer: got %b exp 1", bus.icon_tx.req_valid);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.icon_tx !== '0 || bus.busy !== 1'b0 || bus.resp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL rst_async_drop: got tx=%h busy=%b rv=%b exp 0/0/0", bus.icon_tx, bus.busy, bus.resp_valid);
    end
    tick();
    n_tests++;
    if (bus.resp_valid !== 4'b0000 || bus.icon_tx !== '0) begin
      n_fail++; $display("FAIL rst_hold: got rv=%b tx=%h exp 0/0", bus.resp_valid, bus.icon_tx);
    end
    reset_n = 1'b1;
    bus.req_valid = 4'b1001;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0001 || bus.resp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL rst_ptr_zero: got rdy=%b rv=%b exp 0001/0000", bus.req_ready, bus.resp_valid);
    end
    tick();
    bus.req_valid = 4'b0000;
    bus.icon_rx   = mk_rx(32'h0BAD_F00D, 1'b1, 1'b1);
    tick();
    bus.icon_rx = '0;
    #1;
    n_tests++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_data !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL rst_followup_resp: got v=%b d=%h exp 0001/0badf00d", bus.resp_valid, bus.resp_data);
    end
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.icon_rx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_src_addr[i] = 16'hA000 + 16'(i);
      bus.req_data[i]     = 32'hD000_0000 + 32'(i);
    end
    test_reset();
    test_round_robin();
    test_single();
    test_retry();
    test_timeout();
    test_success_at_timeout();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/back_iconch_arbiter.md
BACK_ICONCH_ARBITER -- requirements
Module: back_iconch_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesting execution units (EUs); legal range 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum number of cycles a transfer may wait for channel data; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_i, input, NUM_REQ bits: per-requester request strobe, held high until accepted.
REQ-006 SHALL have port req_src_addr_i, input, NUM_REQ x type_exec_unit_addr: per-requester source operand address.
REQ-007 SHALL have port req_data_i, input, NUM_REQ x type_exec_unit_data: per-requester payload placed on data_tx.
REQ-008 SHALL have port req_ready_o, output, NUM_REQ bits: one-hot acceptance pulse for a request.
REQ-009 SHALL have port resp_valid_o, output, NUM_REQ bits: one-hot completion pulse.
REQ-010 SHALL have port resp_data_o, output, type_exec_unit_data: returned data, valid with resp_valid_o.
REQ-011 SHALL have port resp_err_o, output, 1 bit: high with resp_valid_o when the transfer timed out.
REQ-012 SHALL have port icon_tx_o, output, type_icon_tx_channel_chside: the channel broadcast carrying src_addr, data_tx and req_valid.
REQ-013 SHALL have port icon_rx_i, input, type_icon_rx_channel_chside: the channel return carrying data_rx, data_valid_rx and success.
REQ-014 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the states IDLE, XFER and DONE.
REQ-016 In IDLE with any req_valid_i bit high, SHALL grant exactly one requester by round-robin, starting the search at rr_ptr.
REQ-017 On a grant, SHALL pulse the granted bit of req_ready_o for one cycle.
REQ-018 On a grant, SHALL capture the requester's index, src_addr and data into internal registers.
REQ-019 On a grant, SHALL clear the timeout counter and enter XFER on the next cycle.
REQ-020 In XFER, SHALL drive icon_tx_o.req_valid=1, with src_addr and data_tx taken from the captured registers; these fields SHALL stay stable for the whole of XFER.
REQ-021 Outside XFER, SHALL drive icon_tx_o to all zeros.
REQ-022 In XFER, when icon_rx_i.data_valid_rx=1 and icon_rx_i.success=1 in the same cycle, SHALL capture data_rx and enter DONE with the error flag cleared.
REQ-023 In XFER, when data_valid_rx=1 and success=0, SHALL stay in XFER and continue the transfer (retry).
REQ-024 In XFER, SHALL increment the timeout counter each cycle in which no successful completion occurs.
REQ-025 When the counter reaches TIMEOUT_CYCLES, SHALL enter DONE with the error flag set and resp_data_o=0.
REQ-026 If success and timeout occur in the same cycle, success SHALL win.
REQ-027 In DONE, SHALL assert resp_valid_o for the captured index only, for exactly one cycle.
REQ-028 In DONE, SHALL drive resp_data_o and resp_err_o from the captured values.
REQ-029 In DONE, SHALL set rr_ptr to (captured index + 1) mod NUM_REQ and return to IDLE.
REQ-030 resp_data_o and resp_err_o SHALL be 0 whenever resp_valid_o is 0.
REQ-031 Minimum latency SHALL be: grant in cycle 0, req_valid in cycle 1, DONE in cycle 2 when the channel returns success in cycle 1.
REQ-032 SHALL not accept a new grant in XFER or DONE; back-to-back transfers SHALL therefore be separated by one IDLE cycle.
REQ-033 A requester dropping req_valid_i during XFER SHALL not abort the transfer.
REQ-034 The round-robin search SHALL wrap from index NUM_REQ-1 to index 0.

Reset
REQ-035 While reset_n=0, SHALL force state=IDLE, rr_ptr=0, the timeout counter=0 and all captured registers=0.
REQ-036 While reset_n=0, all outputs SHALL be 0.
REQ-037 A reset asserted mid-XFER SHALL drop icon_tx_o.req_valid immediately (asynchronously) and SHALL produce no response pulse.

Structure
REQ-038 type_exec_unit_addr, type_exec_unit_data and the channel-side structs SHALL come from pkg_dtypes.
REQ-039 The state enum type_iconch_arb_state SHALL be added to pkg_dtypes.
REQ-040 The round-robin priority selector SHALL be a sub-module, back_rr_arbiter, parameterised by NUM_REQ and returning a one-hot grant plus an index.
REQ-041 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-042 Scenario 1 SHALL drive req_valid_i=4'b0100 with a channel returning success one cycle later -> req_ready_o=4'b0100 in cycle 0, icon_tx_o.req_valid in cycle 1, resp_valid_o=4'b0100 in cycle 2 with resp_err_o=0 and resp_data_o equal to data_rx.
REQ-043 Scenario 2 SHALL hold req_valid_i=4'b1111 with immediate success -> grants in the order 0,1,2,3,0, each followed by its response.
REQ-044 Scenario 3 SHALL drive data_valid_rx=1 with success=0 for 3 cycles and then success=1 -> req_valid held for 4 cycles, single response with resp_err_o=0.
REQ-045 Scenario 4 SHALL return no data with TIMEOUT_CYCLES=15 -> resp_valid_o with resp_err_o=1 and resp_data_o=0 after 15 XFER cycles, after which rr_ptr has advanced.
REQ-046 Scenario 5 SHALL deassert reset_n during XFER -> icon_tx_o=0 and busy_o=0 with no resp_valid_o, and after release the next request is granted starting from index 0.
REQ-047 Scenario 6 SHALL assert success in the timeout cycle -> resp_err_o=0 and the captured data is returned.
